// File: rtl/stopwatch_lap_mem_if.sv
// Control, status and lap-readout signals between the stopwatch and the
// button/display logic.
interface stopwatch_lap_mem_if #(
  parameter int CNT_W     = 16,
  parameter int LAP_DEPTH = 8
);
  localparam int ADDR_W = $clog2(LAP_DEPTH);

  logic              start;
  logic              pause;
  logic              clear;
  logic              lap;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              tick;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
  logic [ADDR_W:0]   lap_count;
  logic              lap_full;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;

  modport master (
    output start, pause, clear, lap, rd_en, rd_addr,
    input  tick, count, state, lap_count, lap_full, rd_data, rd_valid
  );

  modport slave (
    input  start, pause, clear, lap, rd_en, rd_addr,
    output tick, count, state, lap_count, lap_full, rd_data, rd_valid
  );
endinterface

// File: rtl/stopwatch_lap_mem.sv
// Stopwatch with prescaled unit counter, run/pause/idle FSM and lap memory.
// Define LAP_WRAP_EN to make the lap memory a ring buffer (oldest lap overwritten).
module stopwatch_lap_mem #(
  parameter  int CLK_DIV   = 50000000,
  parameter  int CNT_W     = 16,
  parameter  int LAP_DEPTH = 8,
  localparam int ADDR_W    = $clog2(LAP_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_lap_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  localparam int                   PRESC_W   = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]      DEPTH     = (ADDR_W + 1)'(LAP_DEPTH);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tick_q, tick_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    lap_count_q, lap_count_d;
  logic               lap_we;
  logic               full;

  logic [CNT_W-1:0]   mem [LAP_DEPTH];
  logic [ADDR_W-1:0]  rd_base;
  logic [ADDR_W-1:0]  rd_idx;
  logic               rd_hit;
  logic [CNT_W-1:0]   rd_data_q;
  logic               rd_valid_q;

  assign full = (lap_count_q == DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      count_q     <= '0;
      tick_q      <= 1'b0;
      wr_ptr_q    <= '0;
      lap_count_q <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_q     <= count_d;
      tick_q      <= tick_d;
      wr_ptr_q    <= wr_ptr_d;
      lap_count_q <= lap_count_d;
    end
  end

  // clear overrides everything; a lap captures count_q before any tick update.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    count_d     = count_q;
    tick_d      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    lap_count_d = lap_count_q;
    lap_we      = 1'b0;

    if (bus.clear) begin
      state_d     = IDLE;
      presc_d     = '0;
      count_d     = '0;
      wr_ptr_d    = '0;
      lap_count_d = '0;
    end else begin
      if (bus.lap && (state_q != IDLE)) begin
`ifdef LAP_WRAP_EN
        lap_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!full) begin
          lap_count_d = lap_count_q + 1'b1;
        end
`else
        if (!full) begin
          lap_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          lap_count_d = lap_count_q + 1'b1;
        end
`endif
      end

      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.pause) begin
            state_d = RUN;
            presc_d = '0;
            count_d = '0;
          end
        end
        RUN: begin
          if (!bus.start) begin
            state_d = IDLE;
          end else if (bus.pause) begin
            state_d = PAUSED;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_q + 1'b1;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (!bus.start) begin
            state_d = IDLE;
          end else if (!bus.pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (lap_we) begin
      mem[wr_ptr_q] <= count_q;
    end
  end

  // Once the ring is full the write pointer sits on the oldest entry.
`ifdef LAP_WRAP_EN
  assign rd_base = full ? wr_ptr_q : '0;
`else
  assign rd_base = '0;
`endif
  assign rd_idx = rd_base + bus.rd_addr;
  assign rd_hit = ({1'b0, bus.rd_addr} < lap_count_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_hit ? mem[rd_idx] : '0;
      end
    end
  end

  assign bus.tick      = tick_q;
  assign bus.count     = count_q;
  assign bus.state     = state_q;
  assign bus.lap_count = lap_count_q;
  assign bus.lap_full  = full;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_stopwatch_lap_mem.sv
// Scoreboard bench for stopwatch_lap_mem against a queue-based reference model;
// follows LAP_WRAP_EN the same way the design does.
module tb_stopwatch_lap_mem;
  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_lap_mem_if #(.CNT_W(CNT_W), .LAP_DEPTH(DEPTH)) bus ();

  stopwatch_lap_mem #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .LAP_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Reference model: state 0 idle / 1 run / 2 paused, laps oldest-first.
  int m_state, m_presc, m_count, m_tick;
  int laps[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_count = 0; m_tick = 0;
    laps.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("state", int'(bus.state), m_state);
    chk("count", int'(bus.count), m_count);
    chk("tick", int'(bus.tick), m_tick);
    chk("lap_count", int'(bus.lap_count), laps.size());
    chk("lap_full", int'(bus.lap_full), int'(laps.size() == DEPTH));
  endtask

  task automatic model_cycle(input bit st, input bit pa, input bit cl, input bit lp,
                             input bit re, input int ad);
    if (re) exp_q.push_back((ad < laps.size()) ? laps[ad] : 0);
    m_tick = 0;
    if (cl) begin
      m_state = 0; m_presc = 0; m_count = 0;
      laps.delete();
    end else begin
      if (lp && m_state != 0) begin
        if (laps.size() < DEPTH) laps.push_back(m_count);
`ifdef LAP_WRAP_EN
        else begin
          void'(laps.pop_front());
          laps.push_back(m_count);
        end
`endif
      end
      case (m_state)
        0: if (st && !pa) begin m_state = 1; m_presc = 0; m_count = 0; end
        1: begin
          if (!st) m_state = 0;
          else if (pa) m_state = 2;
          else if (m_presc == CLK_DIV - 1) begin
            m_presc = 0;
            m_count = (m_count + 1) % (1 << CNT_W);
            m_tick = 1;
          end else m_presc = m_presc + 1;
        end
        default: begin
          if (!st) m_state = 0;
          else if (!pa) m_state = 1;
        end
      endcase
    end
  endtask

  // Called at a falling edge: check, drive, advance model, wait one cycle.
  task automatic step(input bit st, input bit pa, input bit cl, input bit lp,
                      input bit re, input int ad);
    logic [31:0] a;
    check_outputs();
    a = ad;
    bus.start = st; bus.pause = pa; bus.clear = cl; bus.lap = lp;
    bus.rd_en = re; bus.rd_addr = a[AW-1:0];
    model_cycle(st, pa, cl, lp, re, ad);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares each rd_valid pulse with the oldest expected read.
  int last_rd = 0;
  always @(posedge clk) begin
    int e;
    #1;
    if (!rst) begin
      last_rd = 0;
    end else begin
      chk("rd_valid", int'(bus.rd_valid), int'(exp_q.size() > 0));
      if (bus.rd_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", int'(bus.rd_data), e);
        last_rd = e;
      end else if (!bus.rd_valid) begin
        chk("rd_hold", int'(bus.rd_data), last_rd);
      end
    end
  end

  initial begin
    reset_dut();

    for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)  step(1, 0, 0, 0, 0, 0);

    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, (i % 9) == 5, 0, 0);
    for (int a = 0; a < 4; a++)  step(1, 1, 0, 0, 1, a);

    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, (i % 4) == 3, 0, 0);
    for (int a = 0; a < 4; a++)  step(1, 1, 0, 0, 1, a);

    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, i);
    step(1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 30; i++) step(1, 0, 0, i == 20, 1, i % 4);
    reset_dut();
    step(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 80) == 0,
           ($urandom % 4) == 0, $urandom % 2, $urandom % 4);
      if (($urandom % 700) == 0) reset_dut();
    end

    step(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("read_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
